// File: rtl/gps_pkg.sv
// rtl/gps_pkg.sv - shared C/A code constants, FSM state type and PRN-to-G2 phase-selector table
package gps_pkg;

    localparam int CA_CODE_LEN = 1023;
    localparam int NCO_W       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SLEW = 2'd2
    } ca_state_e;

    // Feedback masks: bit i is LFSR stage i+1 (stage 10 is the output)
    localparam logic [9:0] G1_TAPS = 10'b10_0000_0100;
    localparam logic [9:0] G2_TAPS = 10'b11_1010_0110;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } g2_tap_t;

    // G2 phase-selector stage pairs (1-based), PRN 1..32
    localparam logic [7:0] G2_TAP_TABLE [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };

    function automatic g2_tap_t prn_taps(input logic [4:0] prn_idx);
        logic [7:0] t;
        g2_tap_t    r;
        t   = G2_TAP_TABLE[prn_idx];
        r.a = t[7:4] - 4'd1;
        r.b = t[3:0] - 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/ca_lfsr.sv
// rtl/ca_lfsr.sv - 10-bit Fibonacci LFSR with all-ones load and single-step control
module ca_lfsr
    import gps_pkg::*;
#(
    parameter logic [9:0] TAPS = G1_TAPS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       step_i,
    output logic [9:0] state_o
);

    logic [9:0] state_q;
    logic [9:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = '1;
        end else if (step_i) begin
            state_d = {state_q[8:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ca_code_gen.sv
// rtl/ca_code_gen.sv - GPS C/A code generator with code NCO; chip slew gated by CA_CODE_SLEW_EN
module ca_code_gen
    import gps_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [5:0]       prn,
    input  logic [NCO_W-1:0] phase_incr,
    input  logic             slew_req,
    input  logic [9:0]       slew_chips,
    output logic             code,
    output logic             epoch,
    output logic [9:0]       chip_idx,
    output logic             running,
    output logic             prn_err,
    output logic             slew_busy
);

    ca_state_e        state_q;
    logic [NCO_W-1:0] phase_q;
    logic             tick_q;
    logic [9:0]       chip_idx_q;
    logic [9:0]       chip_idx_d;
    logic             prn_err_q;
    g2_tap_t          taps_q;
    logic [9:0]       g1_state;
    logic [9:0]       g2_state;
    logic [NCO_W:0]   nco_sum;
    logic             start_ok;
    logic             restart;
    logic             slew_go;
    logic             adv;
    logic             last_chip;
    logic             lfsr_load;
    logic             lfsr_step;

    assign start_ok  = start && (prn != 6'd0) && (prn <= 6'd32);
    assign restart   = !stop && start_ok;
    assign last_chip = (chip_idx_q == 10'(CA_CODE_LEN - 1));
    assign nco_sum   = {1'b0, phase_q} + {1'b0, phase_incr};

`ifdef CA_CODE_SLEW_EN
    logic [9:0] slew_cnt_q;
    assign slew_go   = (state_q == RUN) && slew_req && (slew_chips != 10'd0);
    assign slew_busy = (state_q == SLEW);
`else
    logic unused_slew;
    assign unused_slew = ^{slew_req, slew_chips};
    assign slew_go     = 1'b0;
    assign slew_busy   = 1'b0;
`endif

    always_comb begin
        adv = 1'b0;
        if (!stop && !start_ok) begin
            if (state_q == RUN && !slew_go && tick_q) adv = 1'b1;
`ifdef CA_CODE_SLEW_EN
            if (state_q == SLEW) adv = 1'b1;
`endif
        end
        // A step past the last chip reloads both registers rather than shifting
        lfsr_load  = restart || (adv && last_chip);
        lfsr_step  = adv && !last_chip;
        chip_idx_d = chip_idx_q;
        if (restart) begin
            chip_idx_d = 10'd0;
        end else if (adv) begin
            chip_idx_d = last_chip ? 10'd0 : chip_idx_q + 10'd1;
        end
    end

    ca_lfsr #(.TAPS(G1_TAPS)) u_g1 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .state_o (g1_state)
    );

    ca_lfsr #(.TAPS(G2_TAPS)) u_g2 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .state_o (g2_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            tick_q     <= 1'b0;
            chip_idx_q <= 10'd0;
            prn_err_q  <= 1'b0;
            taps_q     <= prn_taps(5'd0);
`ifdef CA_CODE_SLEW_EN
            slew_cnt_q <= 10'd0;
`endif
        end else begin
            chip_idx_q <= chip_idx_d;
            if (start && !start_ok) prn_err_q <= 1'b1;
            if (stop) begin
                state_q <= IDLE;
                tick_q  <= 1'b0;
            end else if (start_ok) begin
                state_q   <= RUN;
                phase_q   <= '0;
                tick_q    <= 1'b0;
                prn_err_q <= 1'b0;
                taps_q    <= prn_taps(prn[4:0] - 5'd1);
            end else begin
                case (state_q)
                    RUN: begin
                        if (slew_go) begin
`ifdef CA_CODE_SLEW_EN
                            state_q    <= SLEW;
                            slew_cnt_q <= slew_chips;
`endif
                            tick_q <= 1'b0;
                        end else begin
                            phase_q <= nco_sum[NCO_W-1:0];
                            tick_q  <= nco_sum[NCO_W];
                        end
                    end
`ifdef CA_CODE_SLEW_EN
                    SLEW: begin
                        tick_q     <= 1'b0;
                        slew_cnt_q <= slew_cnt_q - 10'd1;
                        if (slew_cnt_q == 10'd1) state_q <= RUN;
                    end
`endif
                    default: tick_q <= 1'b0;
                endcase
            end
        end
    end

    assign code     = (state_q != IDLE) && (g1_state[9] ^ g2_state[taps_q.a] ^ g2_state[taps_q.b]);
    assign epoch    = tick_q && last_chip && (state_q == RUN);
    assign chip_idx = chip_idx_q;
    assign running  = (state_q != IDLE);
    assign prn_err  = prn_err_q;

endmodule

// File: tb/tb_ca_code_gen.sv
// tb/tb_ca_code_gen.sv - scoreboard bench for ca_code_gen against a sequence-level C/A model
module tb_ca_code_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [5:0]  prn;
    logic [31:0] phase_incr;
    logic        slew_req;
    logic [9:0]  slew_chips;
    logic        code;
    logic        epoch;
    logic [9:0]  chip_idx;
    logic        running;
    logic        prn_err;
    logic        slew_busy;

    ca_code_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .prn        (prn),
        .phase_incr (phase_incr),
        .slew_req   (slew_req),
        .slew_chips (slew_chips),
        .code       (code),
        .epoch      (epoch),
        .chip_idx   (chip_idx),
        .running    (running),
        .prn_err    (prn_err),
        .slew_busy  (slew_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit code;
    } exp_t;

    exp_t exp_q[$];
    int   epoch_t[$];
    bit   ref_code [1:32][0:1022];
    int   tap_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int   tap_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         epoch_cnt = 0;
    int         ones_cnt = 0;
    logic [31:0] obs_bits = '0;
    bit         have_prev = 0;
    logic [9:0] prev_idx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sequence form: x[n] built from the characteristic polynomials, stage i at step k is x[k+10-i]
    function automatic void build_ref();
        bit x1 [0:1032];
        bit x2 [0:1032];
        for (int n = 0; n < 10; n++) begin
            x1[n] = 1'b1;
            x2[n] = 1'b1;
        end
        for (int n = 10; n < 1033; n++) begin
            x1[n] = x1[n-3] ^ x1[n-10];
            x2[n] = x2[n-2] ^ x2[n-3] ^ x2[n-6] ^ x2[n-8] ^ x2[n-9] ^ x2[n-10];
        end
        for (int p = 1; p <= 32; p++)
            for (int k = 0; k < 1023; k++)
                ref_code[p][k] = x1[k] ^ x2[k + 10 - tap_a[p-1]] ^ x2[k + 10 - tap_b[p-1]];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (epoch) begin
            epoch_cnt++;
            epoch_t.push_back(cyc);
        end
        if (!running || rst) begin
            have_prev = 0;
        end else begin
            if (!have_prev || chip_idx != prev_idx) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("chip_idx", 32'(chip_idx), 32'(e.idx));
                    check("code", 32'(code), 32'(e.code));
                    obs_bits = {obs_bits[30:0], code};
                    ones_cnt += int'(code);
                end
            end
            have_prev = 1;
            prev_idx  = chip_idx;
        end
    end

    task automatic push_chips(input int p, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx  = i % 1023;
            e.code = ref_code[p][i % 1023];
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [5:0] p, input logic [31:0] incr);
        @(posedge clk); #1;
        prn = p; phase_incr = incr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"}, 32'(code), 32'd0);
        check({tag, "_epoch"}, 32'(epoch), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_prn_err"}, 32'(prn_err), 32'd0);
        check({tag, "_slew_busy"}, 32'(slew_busy), 32'd0);
        check({tag, "_chip_idx"}, 32'(chip_idx), 32'd0);
    endtask

    initial begin
        int n;
        int e0;
        int p;
        int nch;
        logic [9:0] held;
        build_ref();
        rst = 1'b1; start = 1'b0; stop = 1'b0; prn = 6'd1;
        phase_incr = 32'h8000_0000; slew_req = 1'b0; slew_chips = 10'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // PRN 1 at half rate: first ten chips and chip timing
        obs_bits = '0;
        push_chips(1, 10);
        pulse_start(6'd1, 32'h8000_0000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("chip9_timing", 32'(chip_idx), 32'd9);
        @(posedge clk);
        @(negedge clk);
        check("chip10_timing", 32'(chip_idx), 32'd10);
        wait_drain(100);
        check("prn1_first10", 32'(obs_bits[9:0]), 32'b1100100000);

        // Three full periods: epoch spacing and ones balance
        pulse_stop();
        epoch_t.delete();
        epoch_cnt = 0;
        ones_cnt  = 0;
        push_chips(1, 3 * 1023);
        pulse_start(6'd1, 32'h8000_0000);
        repeat (6150) @(negedge clk);
        check("period_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("epoch_count", 32'(epoch_cnt), 32'd3);
        if (epoch_t.size() == 3) begin
            check("epoch_gap1", 32'(epoch_t[1] - epoch_t[0]), 32'd2046);
            check("epoch_gap2", 32'(epoch_t[2] - epoch_t[1]), 32'd2046);
        end
        check("ones_3_periods", 32'(ones_cnt), 32'd1536);

        // Bad PRNs from IDLE, then a valid start clears the error
        pulse_stop();
        pulse_start(6'd0, 32'h8000_0000);
        @(negedge clk);
        check("prn0_err", 32'(prn_err), 32'd1);
        check("prn0_running", 32'(running), 32'd0);
        pulse_start(6'd40, 32'h8000_0000);
        @(negedge clk);
        check("prn40_err", 32'(prn_err), 32'd1);
        check("prn40_running", 32'(running), 32'd0);
        check("prn40_code", 32'(code), 32'd0);
        pulse_start(6'd3, 32'h8000_0000);
        @(negedge clk);
        check("valid_clears_err", 32'(prn_err), 32'd0);
        check("valid_running", 32'(running), 32'd1);

        // Stop and start together: stop wins
        @(posedge clk); #1;
        stop = 1'b1; start = 1'b1; prn = 6'd7;
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        @(negedge clk);
        check("stop_start_running", 32'(running), 32'd0);
        check("stop_start_code", 32'(code), 32'd0);

        // Random PRNs and rates; odd passes freeze and restart without stopping
        for (int it = 0; it < 6; it++) begin
            p   = $urandom_range(1, 32);
            nch = $urandom_range(20, 60);
            if (it % 2 == 0) begin
                pulse_stop();
            end else begin
                @(posedge clk); #1;
                phase_incr = 32'd0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                held = chip_idx;
                repeat (10) @(negedge clk);
                check("freeze_idx", 32'(chip_idx), 32'(held));
            end
            push_chips(p, nch);
            pulse_start(6'(p), 32'h4000_0000 | $urandom());
            wait_drain(8 * nch + 20);
        end

        // Reset mid-period at chip 500
        pulse_stop();
        pulse_start(6'd1, 32'h8000_0000);
        n = 0;
        while (chip_idx != 10'd500 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("reach_500", 32'(chip_idx), 32'd500);
        e0 = epoch_cnt;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_epoch", 32'(epoch_cnt), 32'(e0));
        check_reset_outputs("midrst_hold");
        obs_bits = '0;
        push_chips(1, 10);
        pulse_start(6'd1, 32'h8000_0000);
        wait_drain(100);
        check("restart_first10", 32'(obs_bits[9:0]), 32'b1100100000);

`ifdef CA_CODE_SLEW_EN
        begin
            int  busy;
            bit  done;
            logic [9:0] after_idx;
            n = 0;
            while (chip_idx != 10'd1020 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("reach_1020", 32'(chip_idx), 32'd1020);
            e0 = epoch_cnt;
            slew_req = 1'b1; slew_chips = 10'd10;
            @(posedge clk); #1;
            slew_req = 1'b0;
            busy = 0; done = 0; after_idx = '0;
            repeat (30) begin
                @(negedge clk);
                if (slew_busy) busy++;
                else if (busy > 0 && !done) begin
                    after_idx = chip_idx;
                    done = 1;
                end
            end
            check("slew_busy_cycles", 32'(busy), 32'd10);
            check("slew_end_idx", 32'(after_idx), 32'd7);
            check("slew_no_epoch", 32'(epoch_cnt), 32'(e0));
        end
`endif

        pulse_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ca_code_gen.md
CA_CODE_GEN -- requirements
Module: ca_code_gen

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: start  in  1  one-cycle pulse, load PRN and begin code generation.
REQ-003 SHALL have: stop  in  1  one-cycle pulse, return to IDLE.
REQ-004 SHALL have: prn  in  6  satellite PRN number, valid range 1..32, sampled on start.
REQ-005 SHALL have: phase_incr  in  32  code NCO increment per clk, sampled every cycle.
REQ-006 SHALL have: code  out  1  current C/A chip; drives accumulator add_ena (1 = subtract).
REQ-007 SHALL have: epoch  out  1  one-cycle dump strobe; drives accumulator clk_10.
REQ-008 SHALL have: chip_idx  out  10  index of current chip, 0..1022.
REQ-009 SHALL have: running  out  1  high in RUN and SLEW; prn_err  out  1  sticky, bad PRN on start.
REQ-010 SHALL have: slew_req  in  1  pulse; slew_chips  in  10  chips to skip; slew_busy  out  1.

Function
REQ-011 FSM states SHALL be IDLE, RUN, SLEW.
REQ-012 IDLE -> RUN on start with prn in 1..32: G1 and G2 loaded all-ones, chip_idx=0, NCO phase=0.
REQ-013 start with prn 0 or 33..63 SHALL set prn_err and leave the state unchanged.
REQ-014 start in RUN or SLEW with a valid prn SHALL restart as in REQ-012; a valid start clears prn_err.
REQ-015 stop SHALL force IDLE from any state; stop and start in the same cycle: stop wins.
REQ-016 NCO: 32-bit phase += phase_incr each RUN cycle; carry out registered as tick_r (one-cycle pulse).
REQ-017 On an edge with tick_r=1 in RUN: G1 and G2 step once; chip_idx increments; at 1022 it wraps to 0 and G1/G2 reload all-ones.
REQ-018 G1 = 1+x^3+x^10; G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10; code = G1[10] XOR (G2 tap_a XOR G2 tap_b), taps per PRN from package table.
REQ-019 epoch SHALL equal tick_r AND chip_idx==1022 AND state==RUN: high only in the last sample cycle of each 1023-chip period.
REQ-020 code, epoch, and running SHALL be functions of registers only; no combinational path from any input.
REQ-021 phase_incr=0 SHALL freeze the chip sequence; values >= 2^31 yield at most one tick per cycle.
REQ-022 In IDLE: code=0, epoch=0, chip_idx held, NCO phase held.

Reset
REQ-023 rst SHALL force IDLE, with G1=G2=all-ones, phase=0, tick_r=0, chip_idx=0.
REQ-024 rst SHALL force code=0, epoch=0, running=0, prn_err=0, slew_busy=0.
REQ-025 A latched PRN tap selection SHALL reset to PRN 1.
REQ-026 rst asserted mid-period SHALL abort immediately; no epoch pulse is emitted.

Configuration
REQ-027 Macro CA_CODE_SLEW_EN SHALL gate the slew feature.
REQ-028 With CA_CODE_SLEW_EN: slew_req in RUN with slew_chips>0 enters SLEW.
  - Each clk: one chip step, including the wrap rule of REQ-017.
  - epoch forced 0; NCO held.
  - After slew_chips steps, returns to RUN.
  - slew_busy high throughout SLEW.
  - slew_req in IDLE or SLEW, or with slew_chips=0, is ignored.
REQ-029 Without CA_CODE_SLEW_EN: ports stay present, slew_req is ignored, slew_busy is tied 0, and the SLEW state is not built.

Structure
REQ-030 Shared package gps_pkg SHALL hold:
  - PRN-to-G2-tap table (32 entries).
  - CA_CODE_LEN=1023.
  - NCO_W=32.
  - FSM state enum.
REQ-031 One sub-module, ca_lfsr: a parameterised 10-bit Fibonacci LFSR with load and step inputs, instantiated for G1 and G2.

Verification
REQ-032 PRN 1, phase_incr=0x8000_0000 -> first 10 code chips 1100100000 (octal 1440), one chip per 2 clk.
REQ-033 PRN 1, same increment, 3 periods -> epoch pulses exactly 2046 clk apart; each period has 512 ones and 511 zeros.
REQ-034 PRN 0 on start, then PRN 40 on start -> prn_err=1, running=0, code=0.
REQ-035 rst at chip_idx=500 -> next cycle: all outputs at reset values; after a new start, the sequence matches the start of REQ-032.
REQ-036 With CA_CODE_SLEW_EN: PRN 1, slew 10 chips at chip_idx=1020 -> slew_busy for 10 clk, chip_idx=7, no epoch pulse.
REQ-037 Stop and start in the same cycle -> IDLE, running=0.
